// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART transmit path.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'b000;
  localparam logic [2:0] START  = 3'b001;
  localparam logic [2:0] DATA   = 3'b010;
  localparam logic [2:0] PARITY = 3'b011;
  localparam logic [2:0] STOP   = 3'b100;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StStart  = START,
    StData   = DATA,
    StParity = PARITY,
    StStop   = STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// System-side request, serializer handshake and line outputs of the TX frame controller.
interface uart_tx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_data;
  logic                  ser_load;
  logic                  ser_shift;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    output ser_data,
    input  ser_load,
    input  ser_shift,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    input  ser_data,
    output ser_load,
    output ser_shift,
    output tx_out,
    output busy
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of the outgoing byte; the controller registers it on acceptance.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  // Even parity makes the total count of ones even; odd flips that.
  assign o_parity = (^i_p_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// Frame sequencer for the UART transmitter: start, LSB-first data, optional parity, stop.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_frame_ctrl_if.slave bus
);

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 r_par_bit;
  logic                 w_par_bit_next;
  logic                 r_par_en;
  logic                 w_par_en_next;

  logic                 w_parity;
  logic                 w_accept;
  logic                 w_last_bit;
  logic                 w_tx;
  logic                 w_busy;
  logic                 w_shift;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .i_p_data (bus.p_data),
    .i_par_typ(bus.par_typ),
    .o_parity (w_parity)
  );

  assign w_last_bit = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_par_bit <= w_par_bit_next;
      r_par_en  <= w_par_en_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_par_bit_next = r_par_bit;
    w_par_en_next  = r_par_en;
    w_accept       = 1'b0;
    w_tx           = IDLE_BIT;
    w_busy         = 1'b0;
    w_shift        = 1'b0;

    case (r_state)
      StIdle: begin
        if (bus.data_valid) begin
          w_accept     = 1'b1;
          w_state_next = StStart;
        end
      end
      StStart: begin
        w_tx         = START_BIT;
        w_busy       = 1'b1;
        w_cnt_next   = '0;
        w_state_next = StData;
      end
      StData: begin
        w_tx    = bus.ser_data;
        w_busy  = 1'b1;
        w_shift = 1'b1;
        // Counter holds on the last bit so it never wraps inside a frame.
        if (w_last_bit) begin
          w_state_next = r_par_en ? StParity : StStop;
        end else begin
          w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
      end
      StParity: begin
        w_tx         = r_par_bit;
        w_busy       = 1'b1;
        w_state_next = StStop;
      end
      StStop: begin
        w_tx   = STOP_BIT;
        w_busy = 1'b1;
        // Back-to-back frames: the next start bit follows the stop bit directly.
        if (bus.data_valid) begin
          w_accept     = 1'b1;
          w_state_next = StStart;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (w_accept) begin
      w_par_bit_next = w_parity;
      w_par_en_next  = bus.par_en;
    end
  end

  assign bus.ser_load  = w_accept;
  assign bus.ser_shift = w_shift;
  assign bus.tx_out    = w_tx;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench: fixed frame vectors, hand-written corner sequences and random traffic.
module tb_uart_tx_frame_ctrl;

  logic clk;
  logic rst;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame_ctrl #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Companion serializer: load on ser_load, shift right on ser_shift, LSB back as ser_data.
  logic [7:0] r_shreg;
  always @(posedge clk) begin
    if (bus.ser_load) r_shreg <= bus.p_data;
    else if (bus.ser_shift) r_shreg <= r_shreg >> 1;
  end
  assign bus.ser_data = r_shreg[0];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: queue of line bits still to be sent; is_data marks serializer-shift cycles.
  typedef struct packed {
    logic b;
    logic is_data;
  } lbit_t;
  lbit_t mq[$];

  logic [31:0] cap_tx;
  int          busy_cnt;
  int          load_cnt;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones = 0;
    mq.push_back('{1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      mq.push_back('{d[i], 1'b1});
      ones += int'(d[i]);
    end
    if (pe) mq.push_back('{logic'(ones % 2) ^ pt, 1'b0});
    mq.push_back('{1'b1, 1'b0});
  endtask

  task automatic cap_clear();
    cap_tx   = '0;
    busy_cnt = 0;
    load_cnt = 0;
  endtask

  // One clock: drive inputs, compare all outputs against the model, then advance the model.
  task automatic step(input logic dv, input logic [7:0] pd, input logic pe, input logic pt);
    logic e_tx, e_busy, e_load, e_shift;
    @(negedge clk);
    bus.data_valid = dv;
    bus.p_data     = pd;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    #1;
    e_busy  = (mq.size() != 0);
    e_tx    = e_busy ? mq[0].b : 1'b1;
    e_shift = e_busy && mq[0].is_data;
    e_load  = dv && (mq.size() <= 1);
    check("tx_out", bus.tx_out, e_tx);
    check("busy", bus.busy, e_busy);
    check("ser_load", bus.ser_load, e_load);
    check("ser_shift", bus.ser_shift, e_shift);
    cap_tx   = {cap_tx[30:0], bus.tx_out};
    busy_cnt += int'(bus.busy);
    load_cnt += int'(bus.ser_load);
    if (e_busy) void'(mq.pop_front());
    if (e_load) model_accept(pd, pe, pt);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    int          len;
    logic [31:0] bits;  // line sequence, first cycle in bit len-1
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] mask;
    logic [31:0] exp;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 11, 32'b01010010101};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 11, 32'b01000000001};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 11, 32'b01000000011};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 10, 32'b0001111001};

    rst            = 1'b0;
    bus.data_valid = 1'b0;
    bus.p_data     = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    #1;
    check("reset tx_out", bus.tx_out, 1'b1);
    check("reset busy", bus.busy, 1'b0);
    check("reset ser_load", bus.ser_load, 1'b0);
    check("reset ser_shift", bus.ser_shift, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fixed frames; parity controls and p_data wander mid-frame without effect.
    foreach (vecs[v]) begin
      cap_clear();
      step(1'b1, vecs[v].data, vecs[v].pe, vecs[v].pt);
      for (int i = 0; i < vecs[v].len; i++) step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      mask = (32'd2 << vecs[v].len) - 32'd1;
      exp  = (32'd1 << vecs[v].len) | vecs[v].bits;
      check32("vec stream", cap_tx & mask, exp);
      check32("vec busy len", 32'(busy_cnt), 32'(vecs[v].len));
      check32("vec load cnt", 32'(load_cnt), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Back-to-back: data_valid held through the first stop bit.
    cap_clear();
    step(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) step(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 11; i <= 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check32("b2b stream", cap_tx & 32'h003F_FFFF, {10'b0, 1'b1, 10'b0101010101, 10'b0010101011, 1'b1});
    check32("b2b busy len", 32'(busy_cnt), 32'd20);
    check32("b2b load cnt", 32'(load_cnt), 32'd2);

    // Requests mid-frame are ignored even with new data and parity type.
    cap_clear();
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      if (i == 3 || i == 6) step(1'b1, 8'hFF, 1'b1, 1'b1);
      else step(1'b0, 8'hA5, 1'b1, 1'b0);
    end
    check32("noise stream", cap_tx & 32'h0FFF, 32'b101010010101);
    check32("noise busy len", 32'(busy_cnt), 32'd11);
    check32("noise load cnt", 32'(load_cnt), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset during data bit 4.
    step(1'b1, 8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check("pre-reset busy", bus.busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid-reset tx_out", bus.tx_out, 1'b1);
    check("mid-reset busy", bus.busy, 1'b0);
    check("mid-reset ser_shift", bus.ser_shift, 1'b0);
    mq.delete();
    @(negedge clk);
    bus.data_valid = 1'b0;
    rst            = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    cap_clear();
    step(1'b1, vecs[0].data, vecs[0].pe, vecs[0].pt);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check32("post-reset stream", cap_tx & 32'h0FFF, 32'h0800 | vecs[0].bits);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check32("model drained", 32'(mq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
